alu_instr_feeder: RTL

- Upstream stage of the ALU. It buffers instructions pushed by a loader/testbench through a valid/ready FIFO.
- Presents exactly one registered instruction per clock on the ALU instruction input.
- Inserts bubbles when the FIFO is empty or the ALU has halted. Freezes issue on ALU halt until resume.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_instr_fifo.sv | 41 ++++
 rtl/alu_instr_feeder.sv | 85 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the bubble instruction and the feeder FSM states.
package alu_pkg;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_ADDC = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_LDL  = 4'd10;
  localparam logic [3:0] OP_LDH  = 4'd11;
  localparam logic [3:0] OP_OUT  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd13;

  // OR R0,R0,R0: architecturally a no-op.
  localparam logic [11:0] BUBBLE_INSTR = 12'h000;

  typedef enum logic {RUN, HALTED} feeder_state_e;

endpackage

// File: rtl/alu_instr_fifo.sv
// Synchronous FIFO with wrap-bit pointers; occupancy is derived from the pointer difference.
module alu_instr_fifo #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [PtrW:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PtrW:0]    wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[PtrW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rptr_q[PtrW-1:0]];
  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == (PtrW + 1)'(Depth));
  assign empty_o = (wptr_q == rptr_q);

endmodule

// File: rtl/alu_instr_feeder.sv
// ALU front end: buffers pushed instructions and issues one registered instruction per clock,
// substituting bubbles when empty and freezing on halt until resume.
module alu_instr_feeder
  import alu_pkg::*;
#(
  parameter int unsigned instruction_width = 12,
  parameter int unsigned fifo_depth        = 8,
  parameter int unsigned count_width       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [instruction_width-1:0]   in_instr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           halt_in,
  input  logic                           resume,
  output logic [instruction_width-1:0]   instruction,
  output logic                           issue_valid,
  output logic                           halted,
  output logic [$clog2(fifo_depth):0]    fifo_count,
  output logic [count_width-1:0]         issued_count
);

  feeder_state_e                 state_q;
  logic [instruction_width-1:0]  instr_q;
  logic                          valid_q;
  logic [count_width-1:0]        issued_q;

  logic                          push, pop, full, empty;
  logic [instruction_width-1:0]  head;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  // Pop only when the head is actually being issued this edge.
  assign pop      = (state_q == RUN) && !halt_in && !empty;

  alu_instr_fifo #(
    .Width (instruction_width),
    .Depth (fifo_depth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (in_instr),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      instr_q  <= instruction_width'(BUBBLE_INSTR);
      valid_q  <= 1'b0;
      issued_q <= '0;
    end else begin
      instr_q <= instruction_width'(BUBBLE_INSTR);
      valid_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (halt_in) begin
            state_q <= HALTED;
          end else if (!empty) begin
            instr_q  <= head;
            valid_q  <= 1'b1;
            issued_q <= issued_q + 1'b1;
          end
        end
        HALTED: begin
          // Resume issues a bubble this edge; the first pop follows on the next.
          if (resume) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign instruction  = instr_q;
  assign issue_valid  = valid_q;
  assign halted       = (state_q == HALTED);
  assign issued_count = issued_q;

endmodule
